// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: state encoding,
// timeout defaults and counter sizing.
package mem_access_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_WAIT = 2'b01;
    localparam state_t ST_DONE = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 15;

    // Wide enough for the full 1..255 timeout range.
    localparam int unsigned TIMEOUT_CNT_WIDTH = 8;

    function automatic logic is_access(input logic load, input logic store);
        return load | store;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts WAIT cycles without an acknowledge; terminal flags the cycle on
// which the configured timeout is reached.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = mem_access_ctrl_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    import mem_access_ctrl_pkg::*;

    logic [TIMEOUT_CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMEOUT_CNT_WIDTH'(1);
        end
    end

    // count holds the number of earlier ack-less cycles, so this is the Nth one.
    assign terminal = enable && (count == TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage data access controller: stalls the pipeline while a single
// load/store is outstanding on the data-memory handshake, with bus timeout.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = mem_access_ctrl_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
    input  logic                     i_MemtoRegM,
    input  logic                     i_MemWriteM,
    output logic                     o_StallM,
    output logic                     o_MemReq,
    output logic                     o_MemWE,
    output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]    o_MemWData,
    input  logic                     i_MemAck,
    input  logic [DATA_WIDTH-1:0]    i_MemRData,
    output logic [DATA_WIDTH-1:0]    o_ReadDataM,
    output logic                     o_AccessDoneM,
    output logic                     o_BusErrM
);
    import mem_access_ctrl_pkg::*;

    state_t state;
    logic   access;
    logic   in_idle;
    logic   in_wait;
    logic   in_done;
    logic   start;
    logic   finish;
    logic   timeout_hit;
    logic   err;

    assign access  = is_access(i_MemtoRegM, i_MemWriteM);
    assign in_idle = (state == ST_IDLE);
    assign in_wait = (state == ST_WAIT);
    assign in_done = (state == ST_DONE);
    assign start   = in_idle && access;
    // Ack takes priority over a coincident timeout.
    assign finish  = in_wait && (i_MemAck || timeout_hit);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (i_CLK),
        .rst_n    (i_RST),
        .clear    (!in_wait),
        .enable   (in_wait && !i_MemAck),
        .terminal (timeout_hit)
    );

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (access) state <= ST_WAIT;
                ST_WAIT: if (finish) state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            o_MemReq   <= 1'b0;
            o_MemWE    <= 1'b0;
            o_MemAddr  <= '0;
            o_MemWData <= '0;
        end else if (start) begin
            o_MemReq   <= 1'b1;
            o_MemWE    <= i_MemWriteM;
            o_MemAddr  <= i_ALUOutM;
            o_MemWData <= i_WriteDataM;
        end else if (finish) begin
            o_MemReq   <= 1'b0;
            o_MemWE    <= 1'b0;
            o_MemAddr  <= '0;
            o_MemWData <= '0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            err <= 1'b0;
        end else if (finish) begin
            err <= !i_MemAck;
        end else if (in_done) begin
            err <= 1'b0;
        end
    end

    // Only loads update the result; a timed-out load returns zero.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            o_ReadDataM <= '0;
        end else if (finish && !o_MemWE) begin
            o_ReadDataM <= i_MemAck ? i_MemRData : '0;
        end
    end

    assign o_StallM      = start || in_wait;
    assign o_AccessDoneM = in_done;
    assign o_BusErrM     = in_done && err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int TMO = 15;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic        mem_to_reg;
    logic        mem_write;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] read_data;
    logic        access_done;
    logic        bus_err;

    int tests = 0;
    int fails = 0;

    mem_access_ctrl #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_CLK         (clk),
        .i_RST         (rst_n),
        .i_ALUOutM     (alu_out),
        .i_WriteDataM  (write_data),
        .i_MemtoRegM   (mem_to_reg),
        .i_MemWriteM   (mem_write),
        .o_StallM      (stall),
        .o_MemReq      (mem_req),
        .o_MemWE       (mem_we),
        .o_MemAddr     (mem_addr),
        .o_MemWData    (mem_wdata),
        .i_MemAck      (mem_ack),
        .i_MemRData    (mem_rdata),
        .o_ReadDataM   (read_data),
        .o_AccessDoneM (access_done),
        .o_BusErrM     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic        ack;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_stall, input logic e_req,
                             input logic e_we, input logic [31:0] e_addr,
                             input logic [31:0] e_wdata, input logic [31:0] e_rd,
                             input logic e_done, input logic e_err);
        check({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check({tag, ".req"},   32'(mem_req), 32'(e_req));
        check({tag, ".we"},    32'(mem_we), 32'(e_we));
        check({tag, ".addr"},  mem_addr, e_addr);
        check({tag, ".wdata"}, mem_wdata, e_wdata);
        check({tag, ".rdata"}, read_data, e_rd);
        check({tag, ".done"},  32'(access_done), 32'(e_done));
        check({tag, ".err"},   32'(bus_err), 32'(e_err));
    endtask

    task automatic set_in(input logic ld, input logic st, input logic ack,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata);
        mem_to_reg = ld;
        mem_write  = st;
        mem_ack    = ack;
        alu_out    = addr;
        write_data = wdata;
        mem_rdata  = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access: IDLE detect cycle, then up to 40 cycles holding the
    // instruction with ack on loop cycle ack_at (-1 = never), then one idle cycle.
    task automatic run_access(input logic ld, input logic st, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_at, output int done_idx, output int req_cnt,
                              output int stall_cnt, output int bad, output logic err,
                              output logic [31:0] rd, output logic after_done);
        done_idx = -1;
        req_cnt = 0;
        stall_cnt = 0;
        bad = 0;
        err = 1'b0;
        rd = '0;
        set_in(ld, st, 1'b0, addr, wdata, 32'h0);
        @(negedge clk);
        if (stall) stall_cnt++;
        next_cycle();
        for (int i = 0; i < 40 && done_idx < 0; i++) begin
            set_in(ld, st, (i == ack_at), 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdata);
            @(negedge clk);
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                if (mem_we !== st || mem_addr !== addr || mem_wdata !== wdata) bad++;
            end
            if (access_done) begin
                done_idx = i;
                err = bus_err;
                rd = read_data;
            end
            next_cycle();
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        after_done = access_done;
        next_cycle();
    endtask

    // Transaction-level reference state for the random phase.
    logic        m_busy, m_done, m_err, m_we;
    logic [31:0] m_addr, m_wdata, m_rd;
    int          m_waits;

    initial begin
        int          done_idx, req_cnt, stall_cnt, bad;
        logic        err, after_done;
        logic [31:0] rd;
        logic        r_ld, r_st, r_ack, r_rst;
        logic [31:0] r_addr, r_wdata, r_rdata;
        logic        e_stall, e_req, e_we, e_done, e_err;
        logic [31:0] e_addr, e_wdata;

        vecs[0]  = '{1, 0, 1, 32'h40,  32'hAAAA5555, 32'hBAD0BAD0, 1, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0};
        vecs[1]  = '{1, 0, 1, 32'h44,  32'h0,        32'hDEADBEEF, 1, 1, 0, 32'h40,  32'hAAAA5555, 32'h0,        0, 0};
        vecs[2]  = '{1, 0, 1, 32'h44,  32'h0,        32'h11111111, 0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 1, 0};
        vecs[3]  = '{0, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0, 0};
        vecs[4]  = '{1, 1, 0, 32'h200, 32'hCAFEF00D, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0, 0};
        vecs[5]  = '{1, 1, 1, 32'h200, 32'hCAFEF00D, 32'h77777777, 1, 1, 1, 32'h200, 32'hCAFEF00D, 32'hDEADBEEF, 0, 0};
        vecs[6]  = '{1, 1, 0, 32'h200, 32'hCAFEF00D, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 1, 0};
        vecs[7]  = '{1, 0, 0, 32'h300, 32'h0,        32'h0,        1, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0, 0};
        vecs[8]  = '{1, 0, 0, 32'h300, 32'h0,        32'h0,        1, 1, 0, 32'h300, 32'h0,        32'hDEADBEEF, 0, 0};
        vecs[9]  = '{1, 0, 1, 32'h300, 32'h0,        32'h0BADF00D, 1, 1, 0, 32'h300, 32'h0,        32'hDEADBEEF, 0, 0};
        vecs[10] = '{0, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0BADF00D, 1, 0};
        vecs[11] = '{0, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0BADF00D, 0, 0};

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        next_cycle();
        rst_n = 1'b1;

        // Zero-wait load, ack outside WAIT, load+store then back-to-back load.
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].ld, vecs[i].st, vecs[i].ack, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_req, vecs[i].e_we,
                      vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_rd, vecs[i].e_done, vecs[i].e_err);
            next_cycle();
        end

        run_access(1'b0, 1'b1, 32'h100, 32'h12345678, 32'h0, 2,
                   done_idx, req_cnt, stall_cnt, bad, err, rd, after_done);
        check("store3.done_idx", done_idx, 3);
        check("store3.req_cycles", req_cnt, 3);
        check("store3.stall_cycles", stall_cnt, 4);
        check("store3.unstable", bad, 0);
        check("store3.err", 32'(err), 0);
        check("store3.rdata_held", rd, 32'h0BADF00D);
        check("store3.single_done", 32'(after_done), 0);

        run_access(1'b1, 1'b0, 32'h500, 32'h0, 32'h0, -1,
                   done_idx, req_cnt, stall_cnt, bad, err, rd, after_done);
        check("timeout.done_idx", done_idx, TMO);
        check("timeout.req_cycles", req_cnt, TMO);
        check("timeout.stall_cycles", stall_cnt, TMO + 1);
        check("timeout.unstable", bad, 0);
        check("timeout.err", 32'(err), 1);
        check("timeout.rdata", rd, 32'h0);
        check("timeout.single_done", 32'(after_done), 0);

        run_access(1'b1, 1'b0, 32'h540, 32'h0, 32'h5A5A5A5A, TMO - 1,
                   done_idx, req_cnt, stall_cnt, bad, err, rd, after_done);
        check("ack_last.done_idx", done_idx, TMO);
        check("ack_last.req_cycles", req_cnt, TMO);
        check("ack_last.err", 32'(err), 0);
        check("ack_last.rdata", rd, 32'h5A5A5A5A);
        check("ack_last.single_done", 32'(after_done), 0);

        // Reset in the second WAIT cycle, ack arriving one cycle later.
        set_in(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_mid.idle_stall", 32'(stall), 1);
        next_cycle();
        @(negedge clk);
        check("rst_mid.wait1_req", 32'(mem_req), 1);
        next_cycle();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_mid.wait2_req", 32'(mem_req), 1);
        next_cycle();
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h99999999);
        @(negedge clk);
        check_all("rst_mid.after", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        next_cycle();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check_all("rst_mid.late", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        next_cycle();

        m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_rd = '0; m_waits = 0;
        for (int n = 0; n < 1500; n++) begin
            r_rst   = ($urandom_range(0, 99) != 0);
            r_ld    = ($urandom_range(0, 2) == 0);
            r_st    = ($urandom_range(0, 3) == 0);
            r_ack   = ($urandom_range(0, 3) == 0) && ((n % 200) < 150);
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_rdata = $urandom;
            rst_n = r_rst;
            set_in(r_ld, r_st, r_ack, r_addr, r_wdata, r_rdata);
            @(negedge clk);

            e_stall = 0; e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_done = 0; e_err = 0;
            if (m_done) begin
                e_done = 1;
                e_err  = m_err;
            end else if (m_busy) begin
                e_stall = 1; e_req = 1; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
            end else begin
                e_stall = r_ld | r_st;
            end
            check_all($sformatf("rnd%0d", n), e_stall, e_req, e_we, e_addr, e_wdata, m_rd, e_done, e_err);

            if (!r_rst) begin
                m_busy = 0; m_done = 0; m_err = 0; m_rd = '0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (r_ack) begin
                    m_busy = 0; m_done = 1; m_err = 0;
                    if (!m_we) m_rd = r_rdata;
                end else begin
                    m_waits++;
                    if (m_waits == TMO) begin
                        m_busy = 0; m_done = 1; m_err = 1;
                        if (!m_we) m_rd = '0;
                    end
                end
            end else if (r_ld | r_st) begin
                m_busy = 1; m_we = r_st; m_addr = r_addr; m_wdata = r_wdata; m_waits = 0;
            end
            next_cycle();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
